la_scanctrl: RTL

Scan test controller that drives a single scan chain built from scan flops (`d`/`si`/`se` muxed D-flops sharing one clock). It sits directly upstream of the chain and also consumes its tail output:
- shifts a stimulus pattern in through `scan_si` with `scan_se` high;
- applies a functional capture with `scan_se` low;
- shifts the captured response back out through `scan_so`;
- compares the response against an expected vector.

It is used for built-in structural self-test of small chains and for bring-up of scan stitching.

---
 rtl/la_scan_pkg.sv | 26 ++
 rtl/la_scanctrl_cnt.sv | 28 ++
 rtl/la_scanctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/la_scan_pkg.sv
// Shared definitions for the scan test controller: state encoding and a
// constant-evaluable clog2 helper for sizing the phase counter.
package la_scan_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_UNLOAD  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SHIFT   = ST_SHIFT,
    CAPTURE = ST_CAPTURE,
    UNLOAD  = ST_UNLOAD,
    DONE    = ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/la_scanctrl_cnt.sv
// Loadable down-counter that parks at zero; zero flag marks the last cycle of a phase.
// Load takes effect on the next edge; no backpressure.
module la_scanctrl_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/la_scanctrl.sv
// Scan controller: shift pattern in, capture NCAP cycles, unload and compare.
// done arrives 2N+NCAP+1 cycles after an accepted start; start is ignored unless idle.
module la_scanctrl
  import la_scan_pkg::*;
#(
  parameter     PROP = "DEFAULT",
  parameter int N    = 8,
  parameter int NCAP = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         start,
  input  logic [N-1:0] pattern,
  input  logic [N-1:0] expected,
  output logic         scan_se,
  output logic         scan_si,
  input  logic         scan_so,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] response,
  output logic         fail
);

  localparam int            CW       = clog2((N > NCAP) ? N : NCAP);
  localparam logic [CW-1:0] LD_SHIFT = CW'(N - 1);
  localparam logic [CW-1:0] LD_CAP   = CW'(NCAP - 1);

  state_t        state, nstate;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic [N-1:0]  pat_sr;
  logic [N-1:0]  exp_q;
  logic          accept;
  logic          unload_last;
  logic [N-1:0]  resp_next;

  la_scanctrl_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .nreset   (nreset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (!cnt_load),
    .zero     (cnt_zero)
  );

  always_comb begin
    nstate   = state;
    cnt_load = 1'b0;
    cnt_val  = LD_SHIFT;
    case (state)
      IDLE: begin
        if (start) begin
          nstate   = SHIFT;
          cnt_load = 1'b1;
          cnt_val  = LD_SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          nstate   = CAPTURE;
          cnt_load = 1'b1;
          cnt_val  = LD_CAP;
        end
      end
      CAPTURE: begin
        if (cnt_zero) begin
          nstate   = UNLOAD;
          cnt_load = 1'b1;
          cnt_val  = LD_SHIFT;
        end
      end
      UNLOAD: begin
        if (cnt_zero) nstate = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign accept      = (state == IDLE) && start;
  assign unload_last = (state == UNLOAD) && cnt_zero;
  // Chain tail appears MSB-first, so shifting in at the LSB restores the flop-index mapping.
  assign resp_next   = {response[N-2:0], scan_so};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      pat_sr   <= '0;
      exp_q    <= '0;
      response <= '0;
      fail     <= 1'b0;
      scan_se  <= 1'b0;
      scan_si  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= nstate;
      scan_se <= (nstate == SHIFT) || (nstate == UNLOAD);
      busy    <= (nstate == SHIFT) || (nstate == CAPTURE) || (nstate == UNLOAD);
      done    <= (nstate == DONE);

      // scan_si is set one edge early so it is stable for the whole shift cycle.
      if (accept) begin
        scan_si <= pattern[N-1];
      end else if ((state == SHIFT) && (nstate == SHIFT)) begin
        scan_si <= pat_sr[N-1];
      end else begin
        scan_si <= 1'b0;
      end

      if (accept) begin
        pat_sr <= pattern << 1;
        exp_q  <= expected;
      end else if (state == SHIFT) begin
        pat_sr <= pat_sr << 1;
      end

      if (accept) begin
        response <= '0;
        fail     <= 1'b0;
      end else if (state == UNLOAD) begin
        response <= resp_next;
        if (unload_last) fail <= (resp_next != exp_q);
      end
    end
  end

endmodule
